// File: rtl/data_mem_bridge.sv
// data_mem_bridge: turns each single-cycle CPU load/store into one valid/ready memory transaction,
// stalling the pipeline until it completes. Define DMB_POSTED_WRITE_EN for a one-entry posted store buffer.
module data_mem_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_write,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic [3:0]                 cpu_data_mem_write_strobe,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [DATA_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]      mem_req_wdata,
    output logic [3:0]                 mem_req_strobe,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rsp_rdata,
    output logic                       mem_timeout_err
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       req_valid_q;
    logic                       req_write_q;
    logic [DATA_ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0]      req_wdata_q;
    logic [3:0]                 req_strobe_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       err_q;
`ifdef DMB_POSTED_WRITE_EN
    logic                       posted_q;
`endif

    logic [CNT_W-1:0]           cnt_inc_s;
    logic                       limit_hit_s;
    logic                       cpu_access_s;
    logic                       idle_hazard_s;
    logic                       busy_hazard_s;
    logic                       done_hazard_s;
    logic                       hazard_s;

    // Response-wait counter arithmetic and limit detection.
    always_comb begin
        cnt_inc_s   = cnt_q + CNT_ONE;
        limit_hit_s = (cnt_inc_s == CNT_LIMIT);
    end

    // Stall decode: which pending CPU access must hold the pipeline in each state.
    always_comb begin
        cpu_access_s = cpu_data_mem_read | cpu_data_mem_write;
`ifdef DMB_POSTED_WRITE_EN
        // A draining posted store only stalls the CPU when it presents another access.
        idle_hazard_s = cpu_data_mem_read;
        busy_hazard_s = posted_q ? cpu_access_s : 1'b1;
        done_hazard_s = posted_q ? cpu_access_s : 1'b0;
`else
        idle_hazard_s = cpu_access_s;
        busy_hazard_s = 1'b1;
        done_hazard_s = 1'b0;
`endif
        hazard_s = 1'b0;
        case (state_q)
            S_IDLE:            hazard_s = idle_hazard_s;
            S_REQ, S_WAIT_RSP: hazard_s = busy_hazard_s;
            S_DONE:            hazard_s = done_hazard_s;
            default:           hazard_s = 1'b0;
        endcase
    end

    // Transaction sequencer: captures the CPU access, runs the bus handshake, times out the response wait.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            req_valid_q  <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= {DATA_ADDR_WIDTH{1'b0}};
            req_wdata_q  <= {DATA_WIDTH{1'b0}};
            req_strobe_q <= 4'b0000;
            rdata_q      <= {DATA_WIDTH{1'b0}};
            err_q        <= 1'b0;
`ifdef DMB_POSTED_WRITE_EN
            posted_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_data_mem_write) begin
                        state_q      <= S_REQ;
                        req_valid_q  <= 1'b1;
                        req_write_q  <= 1'b1;
                        req_addr_q   <= cpu_data_mem_waddr;
                        req_wdata_q  <= cpu_data_mem_wdata;
                        req_strobe_q <= cpu_data_mem_write_strobe;
`ifdef DMB_POSTED_WRITE_EN
                        posted_q     <= 1'b1;
`endif
                    end else if (cpu_data_mem_read) begin
                        state_q      <= S_REQ;
                        req_valid_q  <= 1'b1;
                        req_write_q  <= 1'b0;
                        req_addr_q   <= cpu_data_mem_raddr;
                        req_wdata_q  <= {DATA_WIDTH{1'b0}};
                        req_strobe_q <= 4'b0000;
`ifdef DMB_POSTED_WRITE_EN
                        posted_q     <= 1'b0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= {CNT_W{1'b0}};
                        state_q     <= S_WAIT_RSP;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT_RSP: begin
                    cnt_q <= cnt_inc_s;
                    // A response on the limit cycle takes precedence over the timeout.
                    if (mem_rsp_valid) begin
                        if (!req_write_q) begin
                            rdata_q <= mem_rsp_rdata;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                        state_q <= S_DONE;
                    end else if (limit_hit_s) begin
                        err_q   <= 1'b1;
                        rdata_q <= {DATA_WIDTH{1'b1}};
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT_RSP;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
`ifdef DMB_POSTED_WRITE_EN
                    posted_q <= 1'b0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_mem_rdata  = rdata_q;
    assign data_mem_hazard = hazard_s;
    assign mem_req_valid   = req_valid_q;
    assign mem_req_write   = req_write_q;
    assign mem_req_addr    = req_addr_q;
    assign mem_req_wdata   = req_wdata_q;
    assign mem_req_strobe  = req_strobe_q;
    assign mem_timeout_err = err_q;

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits between the CPU data-memory port and a multi-cycle data memory with valid/ready request and valid-only response channels.
- Converts each single-cycle CPU load/store in MEM into one bus transaction.
- Holds `data_mem_hazard` high so the pipeline stalls until the access completes, then presents load data for exactly one cycle for MEM_WB capture.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- DATA_ADDR_WIDTH, 32, address width in bits.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_RSP before the timeout abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- cpu_clk  input  1  clock.
- cpu_rst_n  input  1  asynchronous active-low reset.
- cpu_data_mem_read  input  1  load in MEM stage this cycle.
- cpu_data_mem_raddr  input  DATA_ADDR_WIDTH  load address.
- cpu_data_mem_write  input  1  store in MEM stage this cycle.
- cpu_data_mem_waddr  input  DATA_ADDR_WIDTH  store address.
- cpu_data_mem_wdata  input  DATA_WIDTH  store data.
- cpu_data_mem_write_strobe  input  4  byte enables for the store.
- data_mem_rdata  output  DATA_WIDTH  load data to the MEM_WB register.
- data_mem_hazard  output  1  stall request to hazard detection.
- mem_req_valid  output  1  request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_write  output  1  1 = store, 0 = load.
- mem_req_addr  output  DATA_ADDR_WIDTH  request address.
- mem_req_wdata  output  DATA_WIDTH  store data.
- mem_req_strobe  output  4  byte enables; 4'b0000 on loads.
- mem_rsp_valid  input  1  response or write acknowledge.
- mem_rsp_rdata  input  DATA_WIDTH  load response data.
- mem_timeout_err  output  1  sticky timeout flag.

Behaviour:
- Clock and reset: single clock `cpu_clk`. `cpu_rst_n` is asynchronous and active-low.
- Reset state: FSM = IDLE; `mem_req_*` = 0; `data_mem_rdata` = 0; timeout counter = 0; `mem_timeout_err` = 0.
- Reset mid-transaction: abort immediately to IDLE with no retry.
- State machine (IDLE, REQ, WAIT_RSP, DONE):
  - IDLE: if `cpu_data_mem_write` or `cpu_data_mem_read` is high, capture addr/wdata/strobe/type and go to REQ. Write has priority if both are high (illegal; the bench flags it).
  - REQ: `mem_req_valid` = 1. Fields are held stable until `mem_req_valid & mem_req_ready`, then go to WAIT_RSP.
  - WAIT_RSP: on `mem_rsp_valid`, register `mem_rsp_rdata` into `data_mem_rdata` (loads only) and go to DONE.
  - DONE: one cycle, then IDLE.
- Hazard: `data_mem_hazard` is combinational = (IDLE & (read|write)) | REQ | WAIT_RSP. It is low in DONE, so the CPU advances exactly once per access and the same access is never reissued.
- Load data: `data_mem_rdata` holds its value until the next load response. It is valid in DONE.
- Minimum access latency: 3 cycles of stall plus the DONE cycle, given zero-wait ready and response.
- Stray responses: `mem_rsp_valid` outside WAIT_RSP is ignored.
- Timeout:
  - The counter clears on entry to WAIT_RSP and increments each cycle while waiting.
  - When it reaches TIMEOUT_CYCLES without a response: set `mem_timeout_err` (sticky until reset), set `data_mem_rdata` = all-ones, go to DONE.
  - If a response arrives in the same cycle the limit is reached, the response wins and no error is set.
- Back-to-back accesses: the IDLE cycle following DONE may start a new access immediately; one IDLE cycle always separates transactions.

Optional Feature:
- Macro: DMB_POSTED_WRITE_EN.
- When defined:
  - A store in IDLE is captured into a one-entry write buffer and does not raise `data_mem_hazard`; the CPU proceeds the same cycle.
  - The buffer drains through REQ/WAIT_RSP in the background.
  - A second store, or any load, arriving while the buffer is occupied raises hazard until the drain completes (DONE). The load is then issued normally.
- When undefined: stores are blocking exactly as described in Behaviour.

Test Plan:
- Load, zero-wait memory (ready = 1, rsp the cycle after acceptance): read = 1, raddr = 0x100, rsp_rdata = 0xDEADBEEF -> hazard high 3 cycles, DONE cycle with `data_mem_rdata` = 0xDEADBEEF and hazard low, exactly one `mem_req_valid` handshake.
- Store with backpressure, ready low for 5 cycles: waddr = 0x40, wdata = 0x12345678, strobe = 4'b0011 -> req fields stable all 6 REQ cycles, `mem_req_strobe` = 4'b0011, hazard released only in DONE.
- Timeout with TIMEOUT_CYCLES = 8, no response: `mem_timeout_err` rises after 8 WAIT_RSP cycles, `data_mem_rdata` = 0xFFFFFFFF, FSM returns to IDLE, err stays 1.
- Reset asserted in WAIT_RSP, then a late `mem_rsp_valid` after release -> outputs at reset values, stray response ignored, `data_mem_rdata` stays 0.
- Back-to-back load 0x10 then load 0x14 -> two distinct requests, one IDLE gap, each response delivered in its own DONE cycle.
- With DMB_POSTED_WRITE_EN: store 0x20 followed next cycle by load 0x20 -> no hazard on the store, hazard on the load until the write ack, load request issued strictly after the write ack.
